// File: rtl/gate_sweep_pkg.sv
// Shared types and constants for the gate sweep arbiter and its function unit.
package gate_sweep_pkg;

    // Width of a captured 3-input truth table.
    localparam int unsigned TT_W    = 8;
    // Upper bound on the number of requesters sharing the unit.
    localparam int unsigned MAX_REQ = 4;

    // Function select codes as seen on each requester's sel field.
    typedef enum logic [1:0] {
        EXAMPLE = 2'd0,
        AND3    = 2'd1,
        NAND3   = 2'd2,
        INV     = 2'd3
    } fsel_t;

    // Scheduler states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        RESP  = 2'd2
    } state_t;

endpackage

// File: rtl/gate_fu.sv
// Gate library cells and the combinational function unit that muxes them.

// Library cell: y = ~a~b~c | a~b~c | a~b c
module example (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic y
);
    assign y = (~a & ~b & ~c) | (a & ~b & ~c) | (a & ~b & c);
endmodule

// Library cell: 3-input AND.
module and3 (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic y
);
    assign y = a & b & c;
endmodule

// Library cell: 3-input NAND.
module nand3 (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic y
);
    assign y = ~(a & b & c);
endmodule

// Library cell: inverter.
module inv (
    input  logic a,
    output logic y
);
    assign y = ~a;
endmodule

// Purely combinational function unit: all four cells evaluate in parallel,
// fsel picks which result reaches y.
module gate_fu
    import gate_sweep_pkg::*;
(
    input  fsel_t fsel,
    input  logic  a,
    input  logic  b,
    input  logic  c,
    output logic  y
);

    logic y_ex;
    logic y_and;
    logic y_nand;
    logic y_inv;

    example u_example (
        .a (a),
        .b (b),
        .c (c),
        .y (y_ex)
    );

    and3 u_and3 (
        .a (a),
        .b (b),
        .c (c),
        .y (y_and)
    );

    nand3 u_nand3 (
        .a (a),
        .b (b),
        .c (c),
        .y (y_nand)
    );

    inv u_inv (
        .a (a),
        .y (y_inv)
    );

    // Route the selected cell output to y.
    always_comb begin
        y = 1'b0;
        case (fsel)
            EXAMPLE: y = y_ex;
            AND3:    y = y_and;
            NAND3:   y = y_nand;
            INV:     y = y_inv;
            default: y = 1'b0;
        endcase
    end

endmodule

// File: rtl/gate_sweep_arb.sv
// Round-robin scheduler sharing one gate function unit among NREQ (2..4)
// requesters. A grant sweeps all eight {a,b,c} vectors through the unit and
// returns the captured truth table on a valid/ready response.
module gate_sweep_arb
    import gate_sweep_pkg::*;
#(
    parameter int unsigned NREQ = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [2*NREQ-1:0] sel,
    output logic [NREQ-1:0]   gnt,
    output logic              busy,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [1:0]        rsp_id,
    output logic [TT_W-1:0]   rsp_tt
);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_SWEEP = SWEEP;
    localparam logic [1:0] S_RESP  = RESP;

    logic [1:0]             state_q, state_d;
    logic [1:0]             rr_ptr_q, rr_ptr_d;
    logic [1:0]             owner_q, owner_d;
    fsel_t                  fsel_q, fsel_d;
    logic [2:0]             idx_q, idx_d;
    logic [TT_W-1:0]        tt_q, tt_d;
    logic [NREQ-1:0]        gnt_q, gnt_d;

    // Requests and selects widened to the maximum requester count so every
    // index below is a fixed 2-bit owner id regardless of NREQ.
    logic [MAX_REQ-1:0]     req_pad;
    logic [2*MAX_REQ-1:0]   sel_pad;
    logic [MAX_REQ-1:0]     onehot;

    logic                   pick_vld;
    logic [1:0]             pick_id;
    logic [1:0]             pick_nxt;
    logic                   fu_y;

    assign req_pad = MAX_REQ'(req);
    assign sel_pad = (2 * MAX_REQ)'(sel);

    // Round-robin pick: first active request at or after rr_ptr, wrapping at NREQ.
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            int unsigned cand;
            cand = 32'(rr_ptr_q) + i;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!pick_vld && req_pad[cand[1:0]]) begin
                pick_vld = 1'b1;
                pick_id  = cand[1:0];
            end
        end
    end

    // Pointer value following the picked owner, modulo NREQ.
    always_comb begin
        if (pick_id == 2'(NREQ - 1)) begin
            pick_nxt = '0;
        end else begin
            pick_nxt = pick_id + 2'd1;
        end
    end

    // The unit always sees idx; its output is only captured during SWEEP.
    gate_fu u_fu (
        .fsel (fsel_q),
        .a    (idx_q[2]),
        .b    (idx_q[1]),
        .c    (idx_q[0]),
        .y    (fu_y)
    );

    // Next-state logic for the FSM, grant pulse, owner latch and capture register.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        fsel_d   = fsel_q;
        idx_d    = idx_q;
        tt_d     = tt_q;
        gnt_d    = '0;
        onehot   = '0;
        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    onehot[pick_id] = 1'b1;
                    gnt_d    = onehot[NREQ-1:0];
                    owner_d  = pick_id;
                    fsel_d   = fsel_t'(sel_pad[{pick_id, 1'b0} +: 2]);
                    idx_d    = '0;
                    tt_d     = '0;
                    rr_ptr_d = pick_nxt;
                    state_d  = S_SWEEP;
                end
            end
            S_SWEEP: begin
                tt_d[idx_q] = fu_y;
                idx_d       = idx_q + 3'd1;
                if (idx_q == 3'd7) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            fsel_q   <= EXAMPLE;
            idx_q    <= '0;
            tt_q     <= '0;
            gnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            fsel_q   <= fsel_d;
            idx_q    <= idx_d;
            tt_q     <= tt_d;
            gnt_q    <= gnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign busy      = (state_q != S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_id    = owner_q;
    assign rsp_tt    = tt_q;

endmodule

// File: doc/gate_sweep_arb.md
# gate_sweep_arb

Round-robin scheduler that shares one 3-input gate function unit among up to four requesters. Each granted request sweeps the unit through all eight `{a,b,c}` input vectors and returns the captured 8-bit truth table to the owning requester through a valid/ready response. It sits between the gate-level library cells (`example`, `and3`, `nand3`, `inv`) and any characterisation or self-test logic that needs their truth tables.

## Interface
- `NREQ`, default 2 – number of requesters; legal range 2..4.
- `clk` in 1 – single clock; all state updates on the rising edge.
- `reset` in 1 – asynchronous, active-high reset.
- `req` in NREQ – per-requester request level.
  - Held high until the matching `gnt` pulse.
- `sel` in 2*NREQ – function select; requester i uses bits `[2i+1:2i]`.
  - Sampled only at grant.
- `gnt` out NREQ – one-hot grant pulse, one cycle wide.
- `busy` out 1 – high whenever the state is not IDLE.
- `rsp_valid` out 1 – response available.
- `rsp_ready` in 1 – response accepted when high together with `rsp_valid`.
- `rsp_id` out 2 – index of the requester that owns the response.
- `rsp_tt` out 8 – captured truth table.
  - Bit k holds y for `{a,b,c}` = k, with a as the MSB.

## Operation
- Function select (`sel`):
  - 0: `example`, y = ~a~b~c | a~b~c | a~b c
  - 1: `and3`
  - 2: `nand3`
  - 3: `inv` on a
- FSM states: IDLE, SWEEP, RESP.
- IDLE, with `req != 0`:
  - Pick the first set bit at or after `rr_ptr`, scanning upward modulo NREQ.
  - Latch the owner index and its `sel`.
  - Register `gnt[owner]` = 1 for the next cycle.
  - Clear `idx` and `tt`.
  - Set `rr_ptr` to (owner+1) mod NREQ.
  - Go to SWEEP.
- SWEEP:
  - Drive `{a,b,c}` = `idx` into the function unit; the unit is combinational.
  - On each edge, capture `tt[idx]` <= y and increment `idx`.
  - When `idx` = 7, the same edge moves the FSM to RESP.
- RESP:
  - `rsp_valid` = 1; `rsp_id` and `rsp_tt` are held stable.
  - When `rsp_ready` = 1, go to IDLE.
  - `rsp_tt` keeps its last value until the next grant.
- `req` is ignored outside IDLE. A requester still holding `req` when the FSM returns to IDLE is treated as a new request.
- `sel` changes after grant have no effect on the sweep in progress.

## Timing
- Reset values:
  - `gnt` = 0, `busy` = 0, `rsp_valid` = 0, `rsp_id` = 0, `rsp_tt` = 0.
  - `rr_ptr` = 0, `idx` = 0, state = IDLE.
- Cycle numbering: cycle t0 is IDLE with `req` seen.
  - t1: `gnt` pulse; SWEEP with `idx` = 0.
  - t1..t8: `idx` = 0..7.
  - t9: first cycle with `rsp_valid` = 1.
- Latency: 9 cycles from request to response, 8 cycles from grant to response.
- Minimum spacing between consecutive grants is 10 cycles.
  - There is one IDLE bubble after the response handshake; no IDLE-skip path.
- `rsp_ready` held high in the first RESP cycle: `rsp_valid` lasts exactly one cycle.
- Simultaneous requests are resolved by `rr_ptr` priority only.
  - With all requesters continuously active, grants rotate 0, 1, …, NREQ-1, 0.
- Reset asserted mid-SWEEP or mid-RESP:
  - Outputs return to reset values immediately, without waiting for a clock edge.
  - The partial truth table is discarded and no response is issued.
  - The arbitration pointer returns to 0.

## Structure
- Package `gate_sweep_pkg`:
  - enum `fsel_t` (EXAMPLE=0, AND3=1, NAND3=2, INV=3).
  - enum `state_t` (IDLE, SWEEP, RESP).
  - constant `TT_W` = 8.
  - constant `MAX_REQ` = 4.
- Sub-module `gate_fu`:
  - Purely combinational: `fsel`, a, b, c -> y.
  - Instantiates `example`, `and3`, `nand3` and `inv`, and muxes their outputs by `fsel`.
- The arbiter, FSM and capture register live in `gate_sweep_arb`.

## Test plan
- Single request, `sel` = 0 from requester 0:
  - `gnt` = 01 at t1; `rsp_valid` rises at t9.
  - `rsp_tt` = 0x31, `rsp_id` = 0.
- Sweep each function on requester 1 with `sel` = 1, 2, 3 in turn:
  - `rsp_tt` = 0x80, 0x7F and 0x0F respectively.
  - `rsp_id` = 1 for each.
- NREQ = 4, all `req` held high, each response accepted immediately:
  - Grant order 0, 1, 2, 3, 0.
  - Consecutive `gnt` pulses exactly 10 cycles apart.
- Backpressure: `rsp_ready` held low for 5 cycles in RESP, with requester 1 pending:
  - `rsp_valid`, `rsp_tt` and `rsp_id` stay stable.
  - No `gnt` to requester 1 until the cycle after the handshake, plus 1.
- Requester changes `sel` from 1 to 2 at t3 after being granted with `sel` = 1:
  - `rsp_tt` = 0x80, not 0x7F.
- `reset` pulse at t5 of a sweep:
  - All outputs are 0 immediately; no `rsp_valid` appears.
  - A subsequent request completes normally with the correct table.
